audio_mix_sequencer: RTL and testbench
======================================

# audio_mix_sequencer

Click-free sequencer for the stereo mixing mode of the final audio filter. It sits between the Paula stereo sample outputs and the final filter stage, and owns the filter's `mixing[1:0]` select. On a host mode-change request it ramps the signal down in 6 dB steps, switches `mixing` while muted, waits for the filter pipeline to settle, then ramps back up and acknowledges.

## Interface
- `STEP_SAMPLES`, default 64: sample strobes per 6 dB attenuation step; must be ≥1.
- `SETTLE_SAMPLES`, default 4: sample strobes held at mute after the switch; must be ≥1.
- `INIT_MIX`, default 2'd0: `mixing` value after reset.

Ports:
- `audio_clk`  in  1  clock.
- `reset_l`  in  1  asynchronous, active-low reset.
- `sample_en`  in  1  one-cycle strobe; `left_in`/`right_in` valid.
- `left_in`  in  16  signed two's-complement left sample.
- `right_in`  in  16  signed two's-complement right sample.
- `mix_req`  in  1  level; a rising edge requests a mode change.
- `mix_sel`  in  2  requested mixing mode; sampled on the accepted `mix_req` edge.
- `mix_ack`  out  1  one-cycle pulse; requested mode is active and gain is restored.
- `busy`  out  1  high in every state except IDLE.
- `mixing`  out  2  mode select to the final filter.
- `left_out`  out  16  attenuated left sample.
- `right_out`  out  16  attenuated right sample.
- `out_valid`  out  1  one-cycle strobe qualifying `left_out`/`right_out`.

## Operation
- Reset values: state IDLE; `att`=0; step and settle counters 0; `mixing`=`INIT_MIX`; `mix_ack`=0; `busy`=0; `left_out`=`right_out`=0; `out_valid`=0; `mix_req` edge register=0.
- `att`: 5 bits, range 0..16.
  - Datapath on `sample_en`: `out = in >>> att` (arithmetic shift) for `att` 0..15.
  - `att`=16 gives `out`=0 (mute).
  - `out_valid` = `sample_en` delayed by 1 cycle.
- Edge detection: `mix_req` is registered; rising edge = `mix_req & ~mix_req_q`.
- **IDLE**
  - Rising edge and `mix_sel`==`mixing`: `mix_ack` pulses the next cycle; no fade.
  - Rising edge and `mix_sel`≠`mixing`: latch `target`=`mix_sel`, clear the step counter, go to FADE_OUT.
- **FADE_OUT**
  - Each `sample_en` increments the step counter.
  - When the counter reaches `STEP_SAMPLES`-1 on a `sample_en`: counter clears and `att` increments.
  - When `att` becomes 16: go to SWITCH.
- **SWITCH**: one cycle. `mixing` <= `target`; clear the settle counter; go to SETTLE.
- **SETTLE**: count `sample_en`. On the `SETTLE_SAMPLES`-th strobe, go to FADE_IN with the step counter cleared.
- **FADE_IN**
  - Same step counting as FADE_OUT, but `att` decrements.
  - When `att` becomes 0: go to IDLE and pulse `mix_ack` on the same edge.
- Rising edges of `mix_req` while `busy` are ignored, not queued. The requester must re-request after `mix_ack`.
- `sample_en` present in the same cycle as a `att` change: the sample uses the pre-change `att`. The new value applies from the next strobe.
- `sample_en` absent: state holds in every state except SWITCH, and except the IDLE-to-ack path.
- Asynchronous reset mid-sequence: immediately returns to the reset values above. `mixing` reverts to `INIT_MIX`, and no `mix_ack` is issued.

## Timing
- Sample latency: 1 cycle from `sample_en` to `out_valid`.
- Same-mode request: `mix_ack` 2 cycles after the `mix_req` rising edge (1 cycle edge register, 1 cycle decision).
- Full switch duration: 16·`STEP_SAMPLES` + `SETTLE_SAMPLES` + 16·`STEP_SAMPLES` sample strobes, plus 1 SWITCH cycle.
- `mixing` changes exactly once per accepted request, only when `att`=16, at the SWITCH→SETTLE edge.
- `busy` rises the cycle after the accepted edge is evaluated. It falls in the same cycle `mix_ack` is high.

## Test plan
1. Reset, then stream `left_in`=0x4000 and `right_in`=0xC000 with `sample_en` every 4 cycles, no request.
   - Expect `left_out`=0x4000, `right_out`=0xC000.
   - Expect `out_valid` 1 cycle after each strobe.
   - Expect `mixing`=`INIT_MIX`.
2. `STEP_SAMPLES`=2, `SETTLE_SAMPLES`=4; request `mix_sel`=3 from mode 0 with constant input 0x4000.
   - Expect `left_out` sequence 0x4000,0x4000,0x2000,0x2000,0x1000 … then 0.
   - Expect `mixing`=3 only after `att`=16.
   - Expect 4 muted strobes in SETTLE, then the symmetric ramp up.
   - Expect `mix_ack` after 68 strobes total.
3. Request `mix_sel` equal to the current mode: expect `mix_ack` 2 cycles after the edge; `busy` never high; outputs unattenuated.
4. Issue a second `mix_req` rising edge during FADE_IN with a different `mix_sel`.
   - Expect it to be ignored: a single `mix_ack`, and `mixing` equal to the first target.
5. Negative input 0x8001 at `att`=1: expect 0xC000 (arithmetic shift; sign preserved).
6. Assert `reset_l` low during SETTLE.
   - Expect `mixing` back to `INIT_MIX`, outputs 0, `busy`=0, no `mix_ack`.
   - Expect a new request after reset to complete normally.

Source files
------------

// File: rtl/audio_mix_sequencer.sv
// Click-free mixing-mode sequencer: fades stereo audio to mute in 6 dB steps,
// switches the final filter's mixing select while muted, settles, then fades back in.
module audio_mix_sequencer #(
  parameter int         STEP_SAMPLES   = 64,
  parameter int         SETTLE_SAMPLES = 4,
  parameter logic [1:0] INIT_MIX       = 2'd0
) (
  input  logic               audio_clk,
  input  logic               reset_l,
  input  logic               sample_en,
  input  logic signed [15:0] left_in,
  input  logic signed [15:0] right_in,
  input  logic               mix_req,
  input  logic [1:0]         mix_sel,
  output logic               mix_ack,
  output logic               busy,
  output logic [1:0]         mixing,
  output logic signed [15:0] left_out,
  output logic signed [15:0] right_out,
  output logic               out_valid
);

  localparam int STEP_W   = (STEP_SAMPLES > 1) ? $clog2(STEP_SAMPLES) : 1;
  localparam int SETTLE_W = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam logic [STEP_W-1:0]   STEP_LAST   = STEP_W'(STEP_SAMPLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_SAMPLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FADE_OUT,
    S_SWITCH,
    S_SETTLE,
    S_FADE_IN
  } state_t;

  state_t              state_reg, state_next;
  logic [4:0]          att_reg, att_next;
  logic [STEP_W-1:0]   step_reg, step_next;
  logic [SETTLE_W-1:0] settle_reg, settle_next;
  logic [1:0]          mixing_reg, mixing_next;
  logic [1:0]          target_reg, target_next;
  logic                ack_reg, ack_next;
  logic                req_d_reg, req_q_reg;
  logic                out_valid_reg;
  logic                req_rise;

  // mix_req is captured first, then compared with its delayed copy
  assign req_rise = req_d_reg & ~req_q_reg;

  always_ff @(posedge audio_clk or negedge reset_l) begin
    if (!reset_l) begin
      state_reg     <= S_IDLE;
      att_reg       <= '0;
      step_reg      <= '0;
      settle_reg    <= '0;
      mixing_reg    <= INIT_MIX;
      target_reg    <= INIT_MIX;
      ack_reg       <= 1'b0;
      req_d_reg     <= 1'b0;
      req_q_reg     <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      att_reg       <= att_next;
      step_reg      <= step_next;
      settle_reg    <= settle_next;
      mixing_reg    <= mixing_next;
      target_reg    <= target_next;
      ack_reg       <= ack_next;
      req_d_reg     <= mix_req;
      req_q_reg     <= req_d_reg;
      out_valid_reg <= sample_en;
    end
  end

  always_comb begin
    state_next  = state_reg;
    att_next    = att_reg;
    step_next   = step_reg;
    settle_next = settle_reg;
    mixing_next = mixing_reg;
    target_next = target_reg;
    ack_next    = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (req_rise) begin
          if (mix_sel == mixing_reg) begin
            ack_next = 1'b1;
          end else begin
            target_next = mix_sel;
            step_next   = '0;
            state_next  = S_FADE_OUT;
          end
        end
      end
      S_FADE_OUT: begin
        if (sample_en) begin
          if (step_reg == STEP_LAST) begin
            step_next = '0;
            att_next  = att_reg + 5'd1;
            if (att_reg == 5'd15) state_next = S_SWITCH;
          end else begin
            step_next = step_reg + STEP_W'(1);
          end
        end
      end
      S_SWITCH: begin
        mixing_next = target_reg;
        settle_next = '0;
        state_next  = S_SETTLE;
      end
      S_SETTLE: begin
        if (sample_en) begin
          if (settle_reg == SETTLE_LAST) begin
            step_next  = '0;
            state_next = S_FADE_IN;
          end else begin
            settle_next = settle_reg + SETTLE_W'(1);
          end
        end
      end
      S_FADE_IN: begin
        if (sample_en) begin
          if (step_reg == STEP_LAST) begin
            step_next = '0;
            att_next  = att_reg - 5'd1;
            if (att_reg == 5'd1) begin
              state_next = S_IDLE;
              ack_next   = 1'b1;
            end
          end else begin
            step_next = step_reg + STEP_W'(1);
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Per-channel attenuator; uses the attenuation in force before any change on this edge
  logic signed [15:0] chan_in [2];
  logic signed [15:0] chan_out_reg [2];

  assign chan_in[0] = left_in;
  assign chan_in[1] = right_in;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic signed [15:0] shifted;
      assign shifted = chan_in[gi] >>> att_reg[3:0];

      always_ff @(posedge audio_clk or negedge reset_l) begin
        if (!reset_l) begin
          chan_out_reg[gi] <= '0;
        end else if (sample_en) begin
          chan_out_reg[gi] <= att_reg[4] ? 16'sd0 : shifted;
        end
      end
    end
  endgenerate

  assign left_out  = chan_out_reg[0];
  assign right_out = chan_out_reg[1];
  assign out_valid = out_valid_reg;
  assign mixing    = mixing_reg;
  assign mix_ack   = ack_reg;
  assign busy      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_audio_mix_sequencer.sv
// Directed bench for audio_mix_sequencer with STEP_SAMPLES=2, SETTLE_SAMPLES=4:
// pass-through, full fade/switch/settle/fade sequence, same-mode ack, ignored re-request, reset abort.
module tb_audio_mix_sequencer;

  logic        audio_clk;
  logic        reset_l;
  logic        sample_en;
  logic [15:0] left_in;
  logic [15:0] right_in;
  logic        mix_req;
  logic [1:0]  mix_sel;
  logic        mix_ack;
  logic        busy;
  logic [1:0]  mixing;
  logic [15:0] left_out;
  logic [15:0] right_out;
  logic        out_valid;

  int vectors = 0;
  int errors  = 0;
  int ack_count = 0;
  int ack_base;

  audio_mix_sequencer #(
    .STEP_SAMPLES  (2),
    .SETTLE_SAMPLES(4),
    .INIT_MIX      (2'd0)
  ) dut (
    .audio_clk(audio_clk),
    .reset_l  (reset_l),
    .sample_en(sample_en),
    .left_in  (left_in),
    .right_in (right_in),
    .mix_req  (mix_req),
    .mix_sel  (mix_sel),
    .mix_ack  (mix_ack),
    .busy     (busy),
    .mixing   (mixing),
    .left_out (left_out),
    .right_out(right_out),
    .out_valid(out_valid)
  );

  initial audio_clk = 1'b0;
  always #5 audio_clk = ~audio_clk;

  always @(negedge audio_clk) begin
    if (mix_ack === 1'b1) ack_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic shift; attenuation 16 means mute
  function automatic logic [15:0] shr(input logic [15:0] v, input int a);
    logic signed [15:0] s;
    s = v;
    if (a >= 16) return 16'h0000;
    return s >>> a;
  endfunction

  // Attenuation seen by strobe n (1-based) of a full sequence with 2 strobes per step, 4 settle
  function automatic int ramp_att(input int n);
    if (n <= 32) return (n - 1) / 2;
    if (n <= 36) return 16;
    return 16 - (n - 37) / 2;
  endfunction

  task automatic strobe(input string tag, input logic [15:0] l, input logic [15:0] r,
                        input logic [15:0] exp_l, input logic [15:0] exp_r);
    @(negedge audio_clk);
    sample_en = 1'b1; left_in = l; right_in = r;
    @(negedge audio_clk);
    sample_en = 1'b0;
    check({tag, "_left"}, 32'(left_out), 32'(exp_l));
    check({tag, "_right"}, 32'(right_out), 32'(exp_r));
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    @(negedge audio_clk);
    check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    @(negedge audio_clk);
  endtask

  task automatic run_seq(input int first, input int last, input logic [1:0] old_mix,
                         input logic [1:0] new_mix);
    for (int n = first; n <= last; n++) begin
      @(negedge audio_clk);
      sample_en = 1'b1; left_in = 16'h4000; right_in = 16'h8001;
      @(negedge audio_clk);
      sample_en = 1'b0;
      check($sformatf("seq%0d_left", n), 32'(left_out), 32'(shr(16'h4000, ramp_att(n))));
      check($sformatf("seq%0d_right", n), 32'(right_out), 32'(shr(16'h8001, ramp_att(n))));
      if (n == 3) check("neg_att1", 32'(right_out), 32'h0000C000);
      if (n == 5) check("att2_left", 32'(left_out), 32'h00001000);
      check($sformatf("seq%0d_valid", n), 32'(out_valid), 32'd1);
      check($sformatf("seq%0d_mixing", n), 32'(mixing), 32'((n <= 32) ? old_mix : new_mix));
      check($sformatf("seq%0d_busy", n), 32'(busy), 32'(n < 68));
      check($sformatf("seq%0d_ack", n), 32'(mix_ack), 32'(n == 68));
      repeat (3) @(negedge audio_clk);
    end
  endtask

  // Raise mix_req; returns after the edge register and decision cycles have both elapsed
  task automatic request(input logic [1:0] sel);
    @(negedge audio_clk);
    mix_sel = sel; mix_req = 1'b1;
    @(negedge audio_clk);
    @(negedge audio_clk);
    mix_req = 1'b0;
  endtask

  initial begin
    reset_l = 1'b0; sample_en = 1'b0; left_in = '0; right_in = '0;
    mix_req = 1'b0; mix_sel = 2'd0;
    repeat (2) @(negedge audio_clk);
    check("rst_mixing", 32'(mixing), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(mix_ack), 32'd0);
    check("rst_left", 32'(left_out), 32'd0);
    check("rst_right", 32'(right_out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    reset_l = 1'b1;
    repeat (2) @(negedge audio_clk);

    // Pass-through with no request
    for (int i = 0; i < 4; i++) begin
      strobe($sformatf("pass%0d", i), 16'h4000, 16'hC000, 16'h4000, 16'hC000);
    end
    check("pass_mixing", 32'(mixing), 32'd0);

    // Full mode change 0 -> 3
    request(2'd3);
    check("t2_busy_rise", 32'(busy), 32'd1);
    run_seq(1, 68, 2'd0, 2'd3);
    check("t2_ack_count", 32'(ack_count), 32'd1);
    check("t2_mixing", 32'(mixing), 32'd3);
    strobe("t2_after", 16'h4000, 16'hC000, 16'h4000, 16'hC000);

    // Same-mode request: ack two edges later, never busy
    @(negedge audio_clk);
    mix_sel = 2'd3; mix_req = 1'b1;
    @(negedge audio_clk);
    check("same_ack_early", 32'(mix_ack), 32'd0);
    check("same_busy1", 32'(busy), 32'd0);
    @(negedge audio_clk);
    check("same_ack", 32'(mix_ack), 32'd1);
    check("same_busy2", 32'(busy), 32'd0);
    mix_req = 1'b0;
    @(negedge audio_clk);
    check("same_ack_drop", 32'(mix_ack), 32'd0);
    check("same_busy3", 32'(busy), 32'd0);
    strobe("same_pass", 16'h4000, 16'hC000, 16'h4000, 16'hC000);
    check("same_ack_count", 32'(ack_count), 32'd2);

    // Re-request during FADE_IN is ignored
    ack_base = ack_count;
    request(2'd1);
    check("t4_busy_rise", 32'(busy), 32'd1);
    run_seq(1, 40, 2'd3, 2'd1);
    request(2'd2);
    check("t4_still_busy", 32'(busy), 32'd1);
    run_seq(41, 68, 2'd3, 2'd1);
    repeat (4) @(negedge audio_clk);
    check("t4_single_ack", 32'(ack_count - ack_base), 32'd1);
    check("t4_mixing", 32'(mixing), 32'd1);

    // Reset during SETTLE aborts without ack
    ack_base = ack_count;
    request(2'd2);
    run_seq(1, 34, 2'd1, 2'd2);
    check("t6_switched", 32'(mixing), 32'd2);
    #2 reset_l = 1'b0;
    #1;
    check("t6_rst_mixing", 32'(mixing), 32'd0);
    check("t6_rst_left", 32'(left_out), 32'd0);
    check("t6_rst_right", 32'(right_out), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    repeat (3) @(negedge audio_clk);
    reset_l = 1'b1;
    repeat (3) @(negedge audio_clk);
    check("t6_no_ack", 32'(ack_count - ack_base), 32'd0);
    check("t6_idle_busy", 32'(busy), 32'd0);
    request(2'd3);
    run_seq(1, 68, 2'd0, 2'd3);
    repeat (4) @(negedge audio_clk);
    check("t6_ack_after", 32'(ack_count - ack_base), 32'd1);
    check("t6_mixing", 32'(mixing), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
